// File: rtl/hex7seg_pkg.sv
// Shared glyph constants and width helpers for the hex 7-segment scanner.
// Glyphs are active-low, bit order g f e d c b a.
package hex7seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int slot_cnt_width(input int prescale);
        return $clog2(prescale);
    endfunction

    function automatic int digit_idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational 4-bit hex nibble to active-low 7-segment glyph decoder.
module hex_seg_dec
    import hex7seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex7seg_scan.sv
// Time-multiplexed common-anode hex display driver with tear-free frame commit.
// Optional leading-zero blanking when HEX7SEG_LZB_EN is defined.
module hex7seg_scan
    import hex7seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  load_i,
    input  logic [2:0]            bright_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int              CW        = slot_cnt_width(PRESCALE);
    localparam int              IW        = digit_idx_width(DIGITS);
    localparam int              PHASE_LEN = PRESCALE / 8;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   sh_val_q, sh_val_d;
    logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d;
    logic                  pending_q, pending_d;
    logic [4*DIGITS-1:0]   dsp_val_q, dsp_val_d;
    logic [DIGITS-1:0]     dsp_dp_q, dsp_dp_d;
    logic [DIGITS-1:0]     dsp_blank_q, dsp_blank_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_q, frame_d;

    logic                  commit;
    logic [DIGITS-1:0]     eff_blank;
    logic [CW-1:0]         phase;
    logic                  lit_slot;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            cur_glyph;

`ifdef HEX7SEG_LZB_EN
    logic [DIGITS-1:0]     lzb_q, lzb_d;
    logic [DIGITS-1:0]     lzb_calc;
    logic                  lzb_seen;

    // Blank zeros from the top digit down until the first nonzero; digit 0 always shows.
    always_comb begin
        lzb_calc = '0;
        lzb_seen = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (!lzb_seen && (sh_val_q[4*k +: 4] == 4'h0)) begin
                lzb_calc[k] = 1'b1;
            end else begin
                lzb_seen = 1'b1;
            end
        end
    end

    assign eff_blank = dsp_blank_q | lzb_q;
`else
    assign eff_blank = dsp_blank_q;
`endif

    assign commit = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // A load on the commit cycle still commits the old shadow, so pending stays set.
    always_comb begin
        sh_val_d    = sh_val_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        pending_d   = pending_q;
        dsp_val_d   = dsp_val_q;
        dsp_dp_d    = dsp_dp_q;
        dsp_blank_d = dsp_blank_q;
`ifdef HEX7SEG_LZB_EN
        lzb_d       = lzb_q;
`endif
        if (commit) begin
            pending_d = 1'b0;
            if (pending_q) begin
                dsp_val_d   = sh_val_q;
                dsp_dp_d    = sh_dp_q;
                dsp_blank_d = sh_blank_q;
`ifdef HEX7SEG_LZB_EN
                lzb_d       = lzb_calc;
`endif
            end
        end
        if (load_i) begin
            sh_val_d   = value_i;
            sh_dp_d    = dp_i;
            sh_blank_d = blank_i;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = dsp_val_q[4*k +: 4];
                cur_dp    = dsp_dp_q[k];
                cur_blank = eff_blank[k];
            end
        end
    end

    hex_seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_glyph)
    );

    // Cycle 0 of every slot is dead time so the previous digit's anode can discharge.
    assign phase    = cnt_q / CW'(PHASE_LEN);
    assign lit_slot = (cnt_q != '0) && (phase <= CW'(bright_i));

    always_comb begin
        an_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                an_d[k] = ~(lit_slot && !eff_blank[k]);
            end
        end
        seg_d   = cur_blank ? SEG_OFF : cur_glyph;
        dp_d    = cur_blank | ~cur_dp;
        frame_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            pending_q   <= 1'b0;
            dsp_val_q   <= '0;
            dsp_dp_q    <= '0;
            dsp_blank_q <= '1;
`ifdef HEX7SEG_LZB_EN
            lzb_q       <= '0;
`endif
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            pending_q   <= pending_d;
            dsp_val_q   <= dsp_val_d;
            dsp_dp_q    <= dsp_dp_d;
            dsp_blank_q <= dsp_blank_d;
`ifdef HEX7SEG_LZB_EN
            lzb_q       <= lzb_d;
`endif
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign an_o      = an_q;
    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign frame_o   = frame_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Self-checking bench for hex7seg_scan: a frame-level reference model predicts
// every registered output cycle by cycle under directed and random stimulus.
module tb_hex7seg_scan;

    localparam int D     = 4;
    localparam int P     = 16;
    localparam int FRAME = D * P;

    logic          clk;
    logic          rst;
    logic [15:0]   value_i;
    logic [3:0]    dp_i;
    logic [3:0]    blank_i;
    logic          load_i;
    logic [2:0]    bright_i;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    an_o;
    logic          frame_o;
    logic          pending_o;

    hex7seg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .value_i   (value_i),
        .dp_i      (dp_i),
        .blank_i   (blank_i),
        .load_i    (load_i),
        .bright_i  (bright_i),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .an_o      (an_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: n counts clock edges since reset release.
    int          n;
    logic [15:0] m_sh_val, m_dsp_val;
    logic [3:0]  m_sh_dp, m_dsp_dp, m_sh_blank, m_dsp_blank, m_lzb;
    logic        m_pend;
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    localparam logic [13:0] RESET_V = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

    function automatic logic [3:0] lzb_of(input logic [15:0] v);
        logic [3:0] m;
        m = 4'h0;
`ifdef HEX7SEG_LZB_EN
        for (int k = D - 1; k >= 1; k--) begin
            if (v[4*k +: 4] != 4'h0) break;
            m[k] = 1'b1;
        end
`else
        m = {3'b000, v[0] & 1'b0};
`endif
        return m;
    endfunction

    task automatic model_reset();
        n           = 0;
        m_sh_val    = '0;
        m_dsp_val   = '0;
        m_sh_dp     = '0;
        m_dsp_dp    = '0;
        m_sh_blank  = '1;
        m_dsp_blank = '1;
        m_lzb       = '0;
        m_pend      = 1'b0;
    endtask

    // Predict the outputs produced by the coming edge, then take that edge.
    task automatic step();
        int pos, idx, cnt;
        logic [3:0] blk, e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        pos = n % FRAME;
        idx = pos / P;
        cnt = pos % P;
        blk = m_dsp_blank | m_lzb;
        e_an = 4'hF;
        if (blk[idx]) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_seg = glyph[m_dsp_val[idx*4 +: 4]];
            e_dp  = ~m_dsp_dp[idx];
            if (cnt != 0 && (cnt / (P / 8)) <= int'(bright_i)) e_an[idx] = 1'b0;
        end
        if (pos == FRAME - 1 && m_pend) begin
            m_dsp_val   = m_sh_val;
            m_dsp_dp    = m_sh_dp;
            m_dsp_blank = m_sh_blank;
            m_lzb       = lzb_of(m_sh_val);
        end
        if (load_i) begin
            m_sh_val   = value_i;
            m_sh_dp    = dp_i;
            m_sh_blank = blank_i;
            m_pend     = 1'b1;
        end else if (pos == FRAME - 1) begin
            m_pend = 1'b0;
        end
        exp_v = {e_an, e_seg, e_dp, (pos == 0), m_pend};
        n++;
        @(posedge clk);
        #1;
        obs_v = {an_o, seg_o, dp_o, frame_o, pending_o};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs_v = {an_o, seg_o, dp_o, frame_o, pending_o};
        checks++;
        if (obs_v !== RESET_V) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_v, RESET_V);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v || an_o !== 4'hF) begin
                errors++;
                $display("FAIL first_frame_dark cyc %0d: got an=%h seg=%h dp=%b fr=%b pend=%b want %h",
                         i, an_o, seg_o, dp_o, frame_o, pending_o, exp_v);
            end
        end
    endtask

    task automatic test_basic();
        value_i  = 16'h1234;
        dp_i     = 4'b0100;
        blank_i  = 4'b0000;
        bright_i = 3'd7;
        load_i   = 1'b1;
        step();
        load_i = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL basic_1234 cyc %0d: got %h want %h (an seg dp fr pend)", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_bright();
        logic [2:0] lv [2] = '{3'd0, 3'd3};
        for (int b = 0; b < 2; b++) begin
            bright_i = lv[b];
            for (int i = 0; i < FRAME; i++) begin
                step();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL bright_%0d cyc %0d: got %h want %h", lv[b], i, obs_v, exp_v);
                end
            end
        end
        bright_i = 3'd7;
    endtask

    task automatic test_back_to_back();
        while ((n % FRAME) != 5) step();
        value_i = 16'hAAAA; dp_i = 4'b0001; blank_i = 4'b0000; load_i = 1'b1;
        step();
        load_i = 1'b0;
        step();
        value_i = 16'h5555; dp_i = 4'b1000; load_i = 1'b1;
        step();
        load_i = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL two_loads cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
        value_i = 16'h9876; dp_i = 4'b0010; load_i = 1'b1;
        step();
        load_i = 1'b0;
        while ((n % FRAME) != FRAME - 1) step();
        value_i = 16'hC0DE; dp_i = 4'b0100; blank_i = 4'b0001; load_i = 1'b1;
        step();
        load_i = 1'b0;
        checks++;
        if (pending_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_cycle_load pending: got %b want 1", pending_o);
        end
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL commit_cycle_load cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_lzb_values();
        logic [15:0] vals [3] = '{16'h0040, 16'h0000, 16'h0305};
        for (int v = 0; v < 3; v++) begin
            value_i = vals[v]; dp_i = 4'b1111; blank_i = 4'b0000; load_i = 1'b1;
            step();
            load_i = 1'b0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                step();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL zero_digits %h cyc %0d: got %h want %h", vals[v], i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            load_i = ($urandom_range(0, 19) == 0);
            if (load_i) begin
                value_i = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, 4'hF,
                                           {4{$urandom_range(0, 1) == 1}}, 4'hF};
                dp_i    = 4'($urandom);
                blank_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            if ((i % 13) == 0) bright_i = 3'($urandom);
            step();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        value_i = 16'h4321; dp_i = 4'b1111; blank_i = 4'b0000; bright_i = 3'd7; load_i = 1'b1;
        step();
        load_i = 1'b0;
        while ((n % FRAME) != FRAME + 2 * P + 5 - FRAME) step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        obs_v = {an_o, seg_o, dp_o, frame_o, pending_o};
        checks++;
        if (obs_v !== RESET_V) begin
            errors++;
            $display("FAIL reset_mid_slot: got %h want %h", obs_v, RESET_V);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v || an_o !== 4'hF) begin
                errors++;
                $display("FAIL after_reset cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        value_i  = '0;
        dp_i     = '0;
        blank_i  = '0;
        load_i   = 1'b0;
        bright_i = 3'd7;
        model_reset();
        test_reset();
        test_basic();
        test_bright();
        test_back_to_back();
        test_lzb_values();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
